ym_voice_scheduler: RTL and testbench

Frame scheduler that time-multiplexes one shared wavetable ROM port across NUM_CH voices. On every 48 kHz sample tick it walks all channels in a fixed order. For each channel it converts the channel's key code to a step size, issues a table read at the channel's phase, accumulates the returned sample, and advances the phase. It ends each frame by emitting one saturated mixed sample. It sits between the register-write bus and the wavetable ROM, replacing per-voice phase generators with a single sequenced datapath.

---
 rtl/ym_voice_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_ym_voice_scheduler.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ym_voice_scheduler.sv
// ym_voice_scheduler: walks NUM_CH voices once per sample tick through one
// shared wavetable ROM port, accumulates the returned samples and emits one
// saturated mixed sample per frame.
//
// ROM handshake: rom_req is a one-cycle strobe with no ready/backpressure;
// rom_addr/rom_sel are valid while rom_req is high, and rom_data must be
// valid in the cycle immediately after rom_req (it is sampled at the end of
// that cycle).
module ym_voice_scheduler #(
  parameter int NUM_CH  = 8,
  parameter int TBL_LEN = 2500,
  parameter int ADDR_W  = 12
) (
  input  logic              phiM,
  input  logic              IC,
  input  logic              sample_tick,
  input  logic              wr_en,
  input  logic [7:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [1:0]        rom_sel,
  input  logic [15:0]       rom_data,
  output logic [15:0]       mix_out,
  output logic              mix_valid,
  output logic              busy,
  output logic              overrun,
  output logic [1:0]        dbg_state
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int ACC_W = 16 + CH_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_OUT     = 2'd3
  } state_t;

  state_t                   state;
  logic [CH_W-1:0]          ch;
  logic signed [ACC_W-1:0]  acc;
  logic                     issued;

  logic [NUM_CH-1:0]        kon;
  logic [ADDR_W-1:0]        phase    [NUM_CH];
  logic [6:0]               key_code [NUM_CH];
  logic [1:0]               wave;

  logic                     kon_wr;
  logic                     kc_wr;
  logic [CH_W-1:0]          kon_idx;
  logic [CH_W-1:0]          kc_idx;
  logic [7:0]               kc_off;
  logic [7:0]               cur_step;
  logic [ADDR_W:0]          phase_sum;
  logic [ADDR_W-1:0]        phase_next;
  logic signed [ACC_W-1:0]  rom_ext;
  logic [15:0]              sat_val;
  logic                     unused_wr_bit;

  // Key code -> phase step: base step per note, then shift by octave around 5.
  function automatic logic [7:0] key_step(input logic [6:0] kc);
    logic [7:0] base;
    logic [2:0] oct;
    oct = kc[6:4];
    case (kc[3:0])
      4'd1:    base = 8'd27;
      4'd2:    base = 8'd29;
      4'd3:    base = 8'd31;
      4'd4:    base = 8'd32;
      4'd5:    base = 8'd34;
      4'd6:    base = 8'd36;
      4'd7:    base = 8'd39;
      4'd8:    base = 8'd41;
      4'd9:    base = 8'd43;
      4'd10:   base = 8'd46;
      4'd11:   base = 8'd49;
      4'd12:   base = 8'd51;
      default: base = 8'd0;
    endcase
    if (oct >= 3'd5) key_step = base << (oct - 3'd5);
    else             key_step = base >> (3'd5 - oct);
  endfunction

  assign unused_wr_bit = wr_data[7];

  // Register-bus decode; channel numbers outside the voice range are dropped.
  always_comb begin
    kc_off  = wr_addr - 8'h28;
    kon_wr  = wr_en && (wr_addr == 8'h08) && (int'(wr_data[2:0]) < NUM_CH);
    kon_idx = CH_W'(wr_data[2:0]);
    kc_wr   = wr_en && (wr_addr >= 8'h28) && (int'(kc_off) < NUM_CH);
    kc_idx  = CH_W'(kc_off);
  end

  // Current-channel datapath: modulo phase advance and sign-extended ROM sample.
  always_comb begin
    cur_step  = key_step(key_code[ch]);
    phase_sum = {1'b0, phase[ch]} + (ADDR_W+1)'(cur_step);
    if (phase_sum >= (ADDR_W+1)'(TBL_LEN))
      phase_next = ADDR_W'(phase_sum - (ADDR_W+1)'(TBL_LEN));
    else
      phase_next = ADDR_W'(phase_sum);
    rom_ext = {{CH_W{rom_data[15]}}, rom_data};
  end

  // Clamp the wide accumulator into the signed 16-bit output range.
  always_comb begin
    if (!acc[ACC_W-1] && (|acc[ACC_W-2:15]))
      sat_val = 16'h7FFF;
    else if (acc[ACC_W-1] && !(&acc[ACC_W-2:15]))
      sat_val = 16'h8000;
    else
      sat_val = acc[15:0];
  end

  assign busy      = (state != S_IDLE);
  assign rom_req   = (state == S_ISSUE) && kon[ch] && (wave != 2'd3);
  assign rom_addr  = rom_req ? phase[ch] : '0;
  assign rom_sel   = rom_req ? wave : 2'd0;
  assign dbg_state = state;

  // Frame sequencer: IDLE -> (ISSUE -> CAPTURE) x NUM_CH -> OUT -> IDLE.
  always_ff @(posedge phiM) begin
    if (IC) begin
      state     <= S_IDLE;
      ch        <= '0;
      acc       <= '0;
      issued    <= 1'b0;
      mix_out   <= 16'h0000;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      overrun   <= sample_tick && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (sample_tick) begin
            ch    <= '0;
            acc   <= '0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          issued <= rom_req;
          state  <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (issued) acc <= acc + rom_ext;
          if (ch == CH_W'(NUM_CH - 1)) begin
            state <= S_OUT;
          end else begin
            ch    <= ch + CH_W'(1);
            state <= S_ISSUE;
          end
        end
        S_OUT: begin
          mix_out   <= sat_val;
          mix_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Per-voice registers; a key-control write to a voice beats its phase advance.
  always_ff @(posedge phiM) begin
    if (IC) begin
      kon  <= '0;
      wave <= 2'd0;
      for (int i = 0; i < NUM_CH; i++) begin
        phase[i]    <= '0;
        key_code[i] <= '0;
      end
    end else begin
      if (wr_en && (wr_addr == 8'h1B)) wave <= wr_data[1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (kon_wr && (kon_idx == CH_W'(i))) begin
          kon[i] <= wr_data[3];
          if (wr_data[3]) phase[i] <= '0;
        end else if ((state == S_CAPTURE) && issued && (ch == CH_W'(i))) begin
          phase[i] <= phase_next;
        end
        if (kc_wr && (kc_idx == CH_W'(i))) key_code[i] <= wr_data[6:0];
      end
    end
  end

endmodule

// File: tb/tb_ym_voice_scheduler.sv
// Bench for ym_voice_scheduler: directed scenarios with literal expectations
// plus a randomized run, all checked every cycle against a frame-level model.
module tb_ym_voice_scheduler;

  localparam int NUM_CH  = 8;
  localparam int TBL_LEN = 2500;
  localparam int ADDR_W  = 12;

  logic              phiM = 1'b0;
  logic              IC = 1'b1;
  logic              sample_tick = 1'b0;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_addr = 8'h00;
  logic [7:0]        wr_data = 8'h00;
  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic [1:0]        rom_sel;
  logic [15:0]       rom_data = 16'h0000;
  logic [15:0]       mix_out;
  logic              mix_valid;
  logic              busy;
  logic              overrun;
  logic [1:0]        dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          chk_en = 1'b0;
  int          rom_mode = 0;
  logic [15:0] rom_const = 16'h0000;
  logic [15:0] exp_q[$];

  int base_tbl [16] = '{0, 27, 29, 31, 32, 34, 36, 39, 41, 43, 46, 49, 51, 0, 0, 0};

  // model state: register file plus frame progress as cycles since the tick
  bit          m_kon   [NUM_CH];
  int          m_phase [NUM_CH];
  logic [6:0]  m_kc    [NUM_CH];
  bit          m_req   [NUM_CH];
  int          m_addr  [NUM_CH];
  int          m_sel   [NUM_CH];
  int          m_wave;
  bit          m_active;
  int          m_fc;
  int          m_acc;
  bit          m_mv;
  bit          m_ov;
  logic [15:0] m_mix;

  logic [15:0]       mx;
  logic [ADDR_W-1:0] la;
  int mvc, mvo, rc, ro, oc, oo;

  ym_voice_scheduler #(.NUM_CH(NUM_CH), .TBL_LEN(TBL_LEN), .ADDR_W(ADDR_W)) dut (
    .phiM(phiM), .IC(IC), .sample_tick(sample_tick), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_sel(rom_sel), .rom_data(rom_data), .mix_out(mix_out), .mix_valid(mix_valid),
    .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 phiM = ~phiM;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rom_fn(input logic [1:0] sel, input logic [ADDR_W-1:0] addr);
    case (rom_mode)
      0:       return 16'(addr);
      1:       return rom_const;
      default: return 16'(int'(addr) * 40503 + int'(sel) * 7919 + 1234);
    endcase
  endfunction

  function automatic int key_step(input logic [6:0] kc);
    int oct, b;
    oct = int'(kc[6:4]);
    b   = base_tbl[kc[3:0]];
    if (oct >= 5) return b * (1 << (oct - 5));
    return b / (1 << (5 - oct));
  endfunction

  function automatic logic [15:0] sat16(input int a);
    if (a > 32767)  return 16'h7FFF;
    if (a < -32768) return 16'h8000;
    return 16'(a);
  endfunction

  // channel issued in the current cycle, -1 when this is not an issue slot
  function automatic int m_issue_ch();
    if (m_active && (m_fc % 2 == 1) && (m_fc <= 2 * NUM_CH - 1)) return (m_fc - 1) / 2;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_kon[i] = 0; m_phase[i] = 0; m_kc[i] = 7'h00;
      m_req[i] = 0; m_addr[i] = 0; m_sel[i] = 0;
    end
    m_wave = 0; m_active = 0; m_fc = 0; m_acc = 0;
    m_mv = 0; m_ov = 0; m_mix = 16'h0000;
    exp_q.delete();
  endfunction

  // reference model, stepped on every rising edge with that cycle's inputs
  always @(posedge phiM) begin : model
    int k, adv_k, adv_p, kw_ch, kc_i;
    bit adv_v, kw_hit, new_ov, new_mv;
    if (IC) begin
      chk_en = 1'b1;
      model_reset();
    end else begin
      new_ov = sample_tick && m_active;
      new_mv = 0; adv_v = 0; adv_k = 0; adv_p = 0;
      if (m_active) begin
        k = m_issue_ch();
        if (k >= 0) begin
          m_req[k]  = m_kon[k] && (m_wave != 3);
          m_addr[k] = m_phase[k];
          m_sel[k]  = m_wave;
        end else if (m_fc % 2 == 0) begin
          k = (m_fc - 2) / 2;
          if (m_req[k]) begin
            m_acc += int'($signed(rom_fn(2'(m_sel[k]), ADDR_W'(m_addr[k]))));
            adv_v = 1; adv_k = k;
            adv_p = (m_phase[k] + key_step(m_kc[k])) % TBL_LEN;
          end
        end
        if (m_fc == 2 * NUM_CH + 1) begin
          m_mix = sat16(m_acc);
          new_mv = 1;
          m_active = 0;
          exp_q.push_back(m_mix);
        end else begin
          m_fc++;
        end
      end else if (sample_tick) begin
        m_active = 1; m_fc = 1; m_acc = 0;
      end
      kw_hit = wr_en && (wr_addr == 8'h08) && (int'(wr_data[2:0]) < NUM_CH);
      kw_ch  = int'(wr_data[2:0]);
      if (adv_v && !(kw_hit && kw_ch == adv_k)) m_phase[adv_k] = adv_p;
      if (kw_hit) begin
        m_kon[kw_ch] = wr_data[3];
        if (wr_data[3]) m_phase[kw_ch] = 0;
      end
      if (wr_en && wr_addr == 8'h1B) m_wave = int'(wr_data[1:0]);
      kc_i = int'(wr_addr) - 40;
      if (wr_en && kc_i >= 0 && kc_i < NUM_CH) m_kc[kc_i] = wr_data[6:0];
      m_mv = new_mv;
      m_ov = new_ov;
    end
  end

  // wavetable ROM: registered read, garbage on cycles without a request
  initial begin : rom_drv
    logic              p_req;
    logic [ADDR_W-1:0] p_addr;
    logic [1:0]        p_sel;
    forever begin
      @(negedge phiM);
      p_req = rom_req; p_addr = rom_addr; p_sel = rom_sel;
      @(posedge phiM);
      #1;
      rom_data = p_req ? rom_fn(p_sel, p_addr) : 16'($urandom);
    end
  end

  // scoreboard: every output every cycle, mix samples through exp_q
  always @(negedge phiM) begin
    int k, e_addr, e_sel;
    bit e_req;
    if (chk_en) begin
      k = m_issue_ch();
      e_req = 0; e_addr = 0; e_sel = 0;
      if (k >= 0) begin
        e_req = m_kon[k] && (m_wave != 3);
        if (e_req) begin e_addr = m_phase[k]; e_sel = m_wave; end
      end
      check("rom_req",   rom_req,   e_req);
      check("rom_addr",  rom_addr,  e_addr);
      check("rom_sel",   rom_sel,   e_sel);
      check("busy",      busy,      m_active);
      check("mix_valid", mix_valid, m_mv);
      check("mix_out",   mix_out,   m_mix);
      check("overrun",   overrun,   m_ov);
      if (mix_valid) begin
        check("mix_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("mix_q_out", mix_out, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge phiM);
    #1;
  endtask

  task automatic do_reset();
    sample_tick = 0; wr_en = 0; IC = 1;
    step();
    IC = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    step();
    wr_en = 0;
  endtask

  // one frame: tick at offset 0, optional extra tick / write / reset at given offsets
  task automatic run_frame(input int tick2_off, input int wr_off, input logic [7:0] wa,
                           input logic [7:0] wd, input int ic_off);
    mvc = 0; mvo = -1; rc = 0; ro = -1; oc = 0; oo = -1; la = '0; mx = 16'h0000;
    step();
    sample_tick = 1;
    for (int i = 1; i <= 2 * NUM_CH + 4; i++) begin
      step();
      sample_tick = (i == tick2_off);
      wr_en = (i == wr_off); wr_addr = wa; wr_data = wd;
      IC = (i == ic_off);
      @(negedge phiM);
      if (rom_req) begin
        rc++;
        if (ro < 0) ro = i;
        la = rom_addr;
      end
      if (mix_valid) begin mvc++; mvo = i; mx = mix_out; end
      if (overrun) begin oc++; oo = i; end
      if (ic_off > 0 && i == ic_off + 1) begin
        check("ic_busy", busy, 0);
        check("ic_rom_req", rom_req, 0);
        check("ic_rom_addr", rom_addr, 0);
        check("ic_mix_out", mix_out, 0);
        check("ic_mix_valid", mix_valid, 0);
      end
    end
    sample_tick = 0; wr_en = 0; IC = 0;
  endtask

  task automatic frame();
    run_frame(0, 0, 8'h00, 8'h00, 0);
  endtask

  initial begin
    repeat (3) step();
    IC = 0;
    @(negedge phiM);
    check("rst_rom_req", rom_req, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_rom_sel", rom_sel, 0);
    check("rst_mix_out", mix_out, 0);
    check("rst_mix_valid", mix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);

    // single voice, ROM returns its address
    rom_mode = 0;
    step();
    wr(8'h28, 8'h51); wr(8'h08, 8'h08); wr(8'h1B, 8'h00);
    frame();
    check("sv1_req_cnt", rc, 1); check("sv1_req_off", ro, 1);
    check("sv1_addr", la, 0); check("sv1_mix", mx, 0); check("sv1_mv_off", mvo, 18);
    frame();
    check("sv2_addr", la, 27); check("sv2_mix", mx, 27);
    frame();
    check("sv3_addr", la, 54); check("sv3_mix", mx, 54);

    // phase wrap with step 204
    do_reset();
    wr(8'h28, 8'h7C); wr(8'h08, 8'h08);
    repeat (12) frame();
    check("wrap_addr12", la, 2244);
    check("wrap_model12", m_phase[0], 2448);
    frame();
    check("wrap_addr13", la, 2448); check("wrap_mix13", mx, 2448);
    check("wrap_model13", m_phase[0], 152);
    frame();
    check("wrap_addr14", la, 152); check("wrap_mix14", mx, 152);

    // saturation, all voices on
    do_reset();
    rom_mode = 1; rom_const = 16'h7000;
    for (int c = 0; c < NUM_CH; c++) begin
      wr(8'(8'h28 + c), 8'h51);
      wr(8'h08, 8'(8'h08 | c));
    end
    frame();
    check("sat_pos_req_cnt", rc, 8); check("sat_pos", mx, 16'h7FFF);
    rom_const = 16'h9000;
    frame();
    check("sat_neg", mx, 16'h8000);

    // skipped channels and waveform 3
    do_reset();
    rom_mode = 0;
    wr(8'h2B, 8'h51); wr(8'h08, 8'h0B);
    frame();
    check("skip_req_cnt", rc, 1); check("skip_req_off", ro, 7); check("skip_mv_off", mvo, 18);
    wr(8'h1B, 8'h03);
    frame();
    check("w3_req_cnt", rc, 0); check("w3_mix", mx, 0); check("w3_mv_off", mvo, 18);

    // overrun, then key-on collision in ch0 capture
    do_reset();
    wr(8'h28, 8'h51); wr(8'h08, 8'h08);
    run_frame(5, 0, 8'h00, 8'h00, 0);
    check("ovr_cnt", oc, 1); check("ovr_off", oo, 6);
    check("ovr_mv_cnt", mvc, 1); check("ovr_mv_off", mvo, 18);
    run_frame(0, 2, 8'h08, 8'h08, 0);
    check("coll_addr_a", la, 27);
    frame();
    check("coll_addr_b", la, 0); check("coll_mix", mx, 0);
    frame();
    check("coll_addr_c", la, 27);

    // reset in the middle of a frame
    run_frame(0, 0, 8'h00, 8'h00, 9);
    check("ic_mv_cnt", mvc, 0);
    frame();
    check("ic_next_req_cnt", rc, 0); check("ic_next_mv_off", mvo, 18);
    check("ic_next_mix", mx, 0);
    wr(8'h28, 8'h51); wr(8'h08, 8'h08);
    frame();
    check("ic_clean_addr", la, 0);

    // randomized traffic
    do_reset();
    rom_mode = 2;
    for (int n = 0; n < 3000; n++) begin
      step();
      sample_tick = ($urandom_range(0, 15) == 0);
      wr_en = ($urandom_range(0, 3) == 0);
      wr_data = 8'($urandom);
      case ($urandom_range(0, 4))
        0:       wr_addr = 8'h08;
        1:       begin wr_addr = 8'h1B; wr_data = 8'($urandom_range(0, 3)); end
        2, 3:    wr_addr = 8'(8'h28 + $urandom_range(0, 9));
        default: wr_addr = 8'($urandom);
      endcase
      IC = ($urandom_range(0, 999) == 0);
    end
    step();
    sample_tick = 0; wr_en = 0; IC = 0;
    repeat (25) step();
    check("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
